// File: rtl/pcie_cfg_pkg.sv
// Shared types and constants for the PCIe configuration-management responders.
package pcie_cfg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDone,
    StHold
  } cfg_state_e;

  localparam logic [31:0] CFG_RD_UNIMPL_FUNC = 32'hFFFF_FFFF;
  localparam logic [31:0] CFG_RD_OOR         = 32'h0;

  localparam int unsigned CFG_CNT_W = 8;
  typedef logic [CFG_CNT_W-1:0] cfg_cnt_t;

endpackage

// File: rtl/cfg_dword_ram.sv
// Dword register file with per-byte write enables, registered read port and
// asynchronous clear of every entry.
module cfg_dword_ram #(
  parameter int unsigned Depth = 64,
  parameter int unsigned Aw    = $clog2(Depth)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [3:0]    be_i,
  input  logic [Aw-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [Aw-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [Depth];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
      rdata_o <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/pcie_us_cfg_mgmt_resp.sv
// cfg_mgmt responder: captures one request, answers it LATENCY cycles later with
// a one-cycle done strobe, then ignores the still-high request level for a cycle.
module pcie_us_cfg_mgmt_resp
  import pcie_cfg_pkg::*;
#(
  parameter int unsigned REG_COUNT = 64,
  parameter int unsigned LATENCY   = 4,
  parameter logic [15:0] VENDOR_ID = 16'h1234,
  parameter logic [15:0] DEVICE_ID = 16'h0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  cfg_mgmt_addr,
  input  logic [7:0]  cfg_mgmt_function_number,
  input  logic        cfg_mgmt_write,
  input  logic [31:0] cfg_mgmt_write_data,
  input  logic [3:0]  cfg_mgmt_byte_enable,
  input  logic        cfg_mgmt_read,
  output logic [31:0] cfg_mgmt_read_data,
  output logic        cfg_mgmt_read_write_done,
  output logic        protocol_error
);

  localparam int unsigned AW = $clog2(REG_COUNT);

  cfg_state_e  state_q;
  cfg_cnt_t    cnt_q;
  logic [9:0]  addr_q;
  logic [7:0]  func_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        rd_q;
  logic        wr_q;

  logic          func_ok;
  logic          in_range;
  logic          wr_ok;
  logic [31:0]   rd_value;
  logic [31:0]   ram_rdata;
  logic [3:0]    ram_be;
  logic [AW-1:0] ram_raddr;

  always_comb begin
    func_ok  = (func_q == 8'd0);
    in_range = ({1'b0, addr_q} < 11'(REG_COUNT));
    wr_ok    = func_ok && in_range && (addr_q != 10'd0);

    rd_value = CFG_RD_OOR;
    if (rd_q && !wr_q) begin
      if (!func_ok) begin
        rd_value = CFG_RD_UNIMPL_FUNC;
      end else if (!in_range) begin
        rd_value = CFG_RD_OOR;
      end else if (addr_q == 10'd0) begin
        rd_value = {DEVICE_ID, VENDOR_ID};
      end else begin
        rd_value = ram_rdata;
      end
    end

    // The write lands on the edge that closes the done cycle (end of HOLD's entry).
    ram_be = (state_q == StHold && wr_q && wr_ok) ? be_q : 4'b0000;
    // Look ahead to the incoming address so LATENCY=1 still sees fresh RAM data.
    ram_raddr = (state_q == StIdle) ? cfg_mgmt_addr[AW-1:0] : addr_q[AW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q                  <= StIdle;
      cnt_q                    <= '0;
      addr_q                   <= '0;
      func_q                   <= '0;
      wdata_q                  <= '0;
      be_q                     <= '0;
      rd_q                     <= 1'b0;
      wr_q                     <= 1'b0;
      cfg_mgmt_read_data       <= '0;
      cfg_mgmt_read_write_done <= 1'b0;
      protocol_error           <= 1'b0;
    end else begin
      cfg_mgmt_read_data       <= '0;
      cfg_mgmt_read_write_done <= 1'b0;
      protocol_error           <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cfg_mgmt_read || cfg_mgmt_write) begin
            addr_q  <= cfg_mgmt_addr;
            func_q  <= cfg_mgmt_function_number;
            wdata_q <= cfg_mgmt_write_data;
            be_q    <= cfg_mgmt_byte_enable;
            rd_q    <= cfg_mgmt_read;
            wr_q    <= cfg_mgmt_write;
            cnt_q   <= cfg_cnt_t'(LATENCY - 1);
            state_q <= (LATENCY == 1) ? StDone : StWait;
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == cfg_cnt_t'(1)) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          cfg_mgmt_read_write_done <= 1'b1;
          protocol_error           <= rd_q && wr_q;
          cfg_mgmt_read_data       <= rd_value;
          state_q                  <= StHold;
        end
        StHold: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  cfg_dword_ram #(
    .Depth(REG_COUNT),
    .Aw   (AW)
  ) u_ram (
    .clk_i  (clk),
    .rst_i  (rst),
    .be_i   (ram_be),
    .waddr_i(addr_q[AW-1:0]),
    .wdata_i(wdata_q),
    .raddr_i(ram_raddr),
    .rdata_o(ram_rdata)
  );

endmodule
